if_id_pipe_stage: RTL and testbench
===================================

// Module: if_id_pipe_stage
// PURPOSE
//   Parametrised IF->ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//   Sits between instruction fetch (ibus + PC) and decode.
//   Adds stall back-pressure, flush (branch redirect) and bubble/NOP insertion to the plain per-cycle latch.
//   Decode sees a stable instr/PC pair and a valid flag; a flushed or empty stage presents NOP_INSTR.
// PARAMETERS
//   IW         32             instruction width (bits)
//   AW         64             PC width (bits)
//   NOP_INSTR  32'hD503201F   value driven on out_instr while out_valid=0 (LEGv8 NOP)
//   CW         16             stall-counter width (only with IF_ID_STALL_CNT_EN)
// PORTS
//   clk          in   1    single clock; all state updates on posedge
//   rst          in   1    synchronous, active-high reset
//   in_valid     in   1    fetch presents a valid instr/PC
//   in_ready     out  1    stage can accept; registered, = !skid_valid
//   in_instr     in   IW   fetched instruction (ibus)
//   in_pc        in   AW   PC of in_instr
//   flush        in   1    discard all held entries (branch taken / redirect)
//   out_valid    out  1    main entry valid for decode
//   out_ready    in   1    decode consumes main entry this cycle
//   out_instr    out  IW   out_valid ? main_instr : NOP_INSTR
//   out_pc       out  AW   main_pc (held value when invalid)
//   stall_cnt    out  CW   [IF_ID_STALL_CNT_EN only] back-pressure cycle count
// BEHAVIOUR
//   Reset (rst=1 at posedge): main_valid=skid_valid=0; main/skid instr and pc regs = 0.
//     Result: out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1, stall_cnt=0. rst overrides all inputs.
//   acc = in_valid & in_ready; drn = out_valid & out_ready.
//   Latency: accepted word appears on out_* the cycle after acceptance (1 cycle); throughput 1/cycle.
//   States by {skid_valid,main_valid}:
//     EMPTY (00): acc -> FULL, main<=in.
//     FULL  (01):
//       acc & drn   -> FULL, main<=in.
//       acc & !drn  -> SKID, skid<=in (main held).
//       !acc & drn  -> EMPTY.
//       else hold.
//     SKID  (11): in_ready=0, so no accept.
//       drn  -> FULL, main<=skid, skid_valid<=0.
//       else hold.
//   State 10 is illegal and never reached.
//   flush=1 (rst=0): next state EMPTY regardless of acc/drn; a word offered that cycle is dropped.
//     Data regs keep old values; in_ready=1 next cycle.
//   Ordering: strict FIFO; the skid entry never bypasses main.
//   in_ready depends only on registered state (no combinational path from out_ready).
//   out_* stay stable while out_valid=1 & out_ready=0.
//   Data regs load only on the transitions above; otherwise hold.
// CONFIGURATION
//   IF_ID_STALL_CNT_EN defined:
//     stall_cnt increments each cycle with out_valid=1 & out_ready=0 & flush=0.
//     Saturates at 2^CW-1; cleared by rst only.
//   Not defined: stall_cnt port and its counter do not exist.
// TESTING
//   1. Reset, then in_valid=1 with in_instr=32'h8B020020, in_pc=64'h40, out_ready=1
//      -> next cycle out_valid=1, out_instr=8B020020, out_pc=40.
//   2. Streaming, out_ready=1, pc 0,4,8,C on consecutive cycles
//      -> same sequence out 1 cycle later, in_ready stays 1.
//   3. FULL, out_ready=0, offer pc=10 then pc=14
//      -> pc=10 accepted into skid, in_ready=0 next cycle, pc=14 held by fetch.
//      Release out_ready -> out_pc 0C,10,14 in order, nothing lost or duplicated.
//   4. SKID state + flush=1
//      -> next cycle out_valid=0, out_instr=D503201F, in_ready=1.
//      pc=80 offered the same cycle as flush is not delivered.
//   5. rst asserted mid-stream while in SKID -> all outputs return to reset values next cycle.
//   6. [IF_ID_STALL_CNT_EN, CW=4] hold out_ready=0 with out_valid=1 for 20 cycles
//      -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/if_id_pipe_stage.sv
// rtl/if_id_pipe_stage.sv - IF->ID pipeline register with valid/ready handshake and 2-entry skid buffer
//
// Purpose:
//   Holds the fetched instr/PC pair for decode. There are two entries, main and skid.
//   The stage supports back-pressure, flush (branch redirect) and NOP presentation
//   while no valid entry is held. Ordering is strict FIFO.
//   Optional build macro IF_ID_STALL_CNT_EN adds a saturating back-pressure counter.
//
// Ports:
//   clk        in   1   clock, all state updates on posedge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   fetch presents a valid instr/PC
//   in_ready   out  1   stage can accept (registered: no skid entry held)
//   in_instr   in   IW  fetched instruction
//   in_pc      in   AW  PC of in_instr
//   flush      in   1   discard all held entries
//   out_valid  out  1   main entry valid for decode
//   out_ready  in   1   decode consumes main entry this cycle
//   out_instr  out  IW  main instr when valid, else NOP_INSTR
//   out_pc     out  AW  main PC (held value when invalid)
//   stall_cnt  out  CW  [IF_ID_STALL_CNT_EN] saturating back-pressure cycle count

module if_id_pipe_stage #(
  parameter int unsigned    IW        = 32,
  parameter int unsigned    AW        = 64,
  parameter logic [IW-1:0]  NOP_INSTR = 32'hD503201F,
  parameter int unsigned    CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [CW-1:0] stall_cnt
`endif
);

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] main_instr_q, main_instr_d;
  logic [AW-1:0] main_pc_q, main_pc_d;
  logic [IW-1:0] skid_instr_q, skid_instr_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;

  logic main_valid;
  logic skid_valid;
  logic acc;
  logic drn;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  // in_ready comes only from registered state, so there is no combinational path
  // from out_ready back to fetch.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_instr = main_valid ? main_instr_q : NOP_INSTR;
  assign out_pc    = main_pc_q;

  assign acc = in_valid & in_ready;
  assign drn = main_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      // A flush drops everything, including a word offered in the same cycle.
      // The data registers keep their old contents.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d      = ST_FULL;
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end
        end
        ST_FULL: begin
          if (acc && drn) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end else if (acc) begin
            // Decode is stalled, so the new word parks behind main.
            state_d      = ST_SKID;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
          end else if (drn) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only a drain can happen.
          if (drn) begin
            state_d      = ST_FULL;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && !flush && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb/tb_if_id_pipe_stage.sv - self-checking bench for if_id_pipe_stage
//
// Purpose:
//   Directed tests covering reset, single transfer, streaming, skid ordering, flush,
//   reset mid-stream and (with IF_ID_STALL_CNT_EN) stall counter saturation.
// Ports: none (top-level bench).

module tb_if_id_pipe_stage;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 64;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
`ifdef IF_ID_STALL_CNT_EN
  logic [3:0]    stall_cnt;
`endif

  int checks;
  int failures;

  if_id_pipe_stage #(
    .IW(IW),
    .AW(AW),
    .NOP_INSTR(NOP),
    .CW(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h12345678; in_pc = 64'h99;
    flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_instr !== NOP) begin failures++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
    checks++; if (out_pc !== 64'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
`ifdef IF_ID_STALL_CNT_EN
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = 32'h8B020020; in_pc = 64'h40; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", out_valid); end
    checks++; if (out_instr !== 32'h8B020020) begin failures++; $display("FAIL single_instr got=%h exp=8b020020", out_instr); end
    checks++; if (out_pc !== 64'h40) begin failures++; $display("FAIL single_pc got=%h exp=40", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%0h exp=0", out_valid); end
    checks++; if (out_instr !== NOP) begin failures++; $display("FAIL single_drain_nop got=%h exp=%h", out_instr, NOP); end
    checks++; if (out_pc !== 64'h40) begin failures++; $display("FAIL single_drain_pc_held got=%h exp=40", out_pc); end
  endtask

  // Leaves the stage FULL with pc=0C in main.
  task automatic test_stream();
    logic [AW-1:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 64'(i * 4);
      in_valid = 1'b1; in_pc = pc; in_instr = 32'hA000_0000 + 32'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== pc || out_instr !== 32'hA000_0000 + 32'(i)) begin
        failures++; $display("FAIL stream_out[%0d] got v=%0h pc=%h instr=%h exp v=1 pc=%h instr=%h",
                             i, out_valid, out_pc, out_instr, pc, 32'hA000_0000 + 32'(i));
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0h exp=1", i, in_ready); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h10; in_instr = 32'hB0000010;
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_in_ready got=%0h exp=0", in_ready); end
    checks++; if (out_pc !== 64'h0C || out_valid !== 1'b1) begin failures++; $display("FAIL skid_main_hold got pc=%h v=%0h exp pc=0c v=1", out_pc, out_valid); end
    in_pc = 64'h14; in_instr = 32'hB0000014;
    tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 64'h0C || out_instr !== 32'hA0000003) begin
      failures++; $display("FAIL skid_stable got rdy=%0h pc=%h instr=%h exp rdy=0 pc=0c instr=a0000003", in_ready, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 64'h10 || out_instr !== 32'hB0000010 || in_ready !== 1'b1) begin
      failures++; $display("FAIL skid_release1 got pc=%h instr=%h rdy=%0h exp pc=10 instr=b0000010 rdy=1", out_pc, out_instr, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 64'h14 || out_instr !== 32'hB0000014 || out_valid !== 1'b1) begin
      failures++; $display("FAIL skid_release2 got pc=%h instr=%h v=%0h exp pc=14 instr=b0000014 v=1", out_pc, out_instr, out_valid);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_no_dup got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h20; in_instr = 32'hC0000020;
    tick();
    in_pc = 64'h24; in_instr = 32'hC0000024;
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_skid got=%0h exp=0", in_ready); end
    flush = 1'b1; in_pc = 64'h80; in_instr = 32'hC0000080;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    checks++; if (out_instr !== NOP) begin failures++; $display("FAIL flush_nop got=%h exp=%h", out_instr, NOP); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_pc80_dropped got=%0h exp=0", out_valid); end
    // Flush in FULL while a word is accepted and main drains: nothing loads.
    in_valid = 1'b1; in_pc = 64'h30; in_instr = 32'hC0000030;
    tick();
    flush = 1'b1; in_pc = 64'h80; in_instr = 32'hC0000080;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_pc !== 64'h30) begin
      failures++; $display("FAIL flush_full_drop got v=%0h pc=%h exp v=0 pc=30", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h40; in_instr = 32'hD0000040;
    tick();
    in_pc = 64'h44;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got rdy=%0h v=%0h exp rdy=0 v=1", in_ready, out_valid);
    end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_outputs got v=%0h instr=%h pc=%h rdy=%0h exp v=0 instr=%h pc=0 rdy=1",
                           out_valid, out_instr, out_pc, in_ready, NOP);
    end
`ifdef IF_ID_STALL_CNT_EN
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_skid_gone got=%0h exp=0", out_valid); end
  endtask

`ifdef IF_ID_STALL_CNT_EN
  task automatic test_stall_cnt();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h50; in_instr = 32'hE0000050;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL stall_cnt_3 got=%0d exp=3", stall_cnt); end
    for (int i = 0; i < 17; i++) tick();
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_cnt_sat got=%0d exp=15", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_cnt_hold got=%0d exp=15", stall_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef IF_ID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
